// File: rtl/theta_slice_feeder.sv
// ----------------------------------------------------------------------------
// theta_slice_feeder
//   Upstream stage of the column-parity (theta) slice datapath. Buffers one
//   full state of NUM_SLICES slices, then streams (previous, current) slice
//   pairs in z order. Slice z-1 wraps to slice NUM_SLICES-1 for z = 0. One
//   state is processed per start pulse.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   start      in   begin loading a new state (honoured only in IDLE)
//   in_slice   in   slice z being loaded, z ascending from 0
//   in_valid   in   in_slice valid
//   in_ready   out  feeder accepts in_slice this cycle (LOAD only)
//   out_prev   out  slice (z-1) mod NUM_SLICES -> parity input1
//   out_curr   out  slice z -> parity input2
//   out_idx    out  z of the current pair
//   out_valid  out  pair valid
//   out_ready  in   downstream accepts pair
//   busy       out  high in LOAD and STREAM
//   done       out  one-cycle pulse after the last pair is accepted
// ----------------------------------------------------------------------------
module theta_slice_feeder #(
    parameter int SLICE_W    = 25,
    parameter int NUM_SLICES = 64,
    parameter int IDX_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SLICE_W-1:0] in_slice,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [SLICE_W-1:0] out_prev,
    output logic [SLICE_W-1:0] out_curr,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    logic [1:0]         r_state;
    logic [SLICE_W-1:0] r_buf [NUM_SLICES];
    logic [IDX_W-1:0]   r_load_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [SLICE_W-1:0] r_prev;
    logic [SLICE_W-1:0] r_curr;
    logic               r_valid;

    logic               w_load_fire;
    logic               w_load_last;
    logic               w_out_fire;
    logic               w_idx_last;
    logic [IDX_W-1:0]   w_idx_nxt;

    assign w_load_fire = (r_state == S_LOAD) && in_valid;
    assign w_load_last = (r_load_cnt == LAST_IDX);
    assign w_out_fire  = (r_state == S_STREAM) && r_valid && out_ready;
    assign w_idx_last  = (r_idx == LAST_IDX);
    assign w_idx_nxt   = r_idx + IDX_W'(1);

    // Slice storage: no reset, contents are don't-care until reloaded.
    always_ff @(posedge clk) begin
        if (w_load_fire) begin
            r_buf[r_load_cnt] <= in_slice;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_load_cnt <= '0;
            r_idx      <= '0;
            r_valid    <= 1'b0;
            r_prev     <= '0;
            r_curr     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_load_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_load_fire) begin
                        r_load_cnt <= r_load_cnt + IDX_W'(1);
                        if (w_load_last) begin
                            // Pair 0 is registered on the final write edge; the
                            // last slice is still on in_slice, so bypass it into
                            // prev instead of waiting for the buffer.
                            r_state <= S_STREAM;
                            r_curr  <= r_buf[0];
                            r_prev  <= in_slice;
                            r_idx   <= '0;
                            r_valid <= 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (w_out_fire) begin
                        if (w_idx_last) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b0;
                        end else begin
                            r_prev <= r_buf[r_idx];
                            r_curr <= r_buf[w_idx_nxt];
                            r_idx  <= w_idx_nxt;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_LOAD);
    assign busy      = (r_state == S_LOAD) || (r_state == S_STREAM);
    assign done      = (r_state == S_DONE);
    assign out_prev  = r_prev;
    assign out_curr  = r_curr;
    assign out_idx   = r_idx;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_theta_slice_feeder.sv
module tb_theta_slice_feeder;

    localparam int SW = 25;
    localparam int N  = 64;
    localparam int IW = 6;

    logic          clk;
    logic          rst;
    logic          start;
    logic          start_main;
    logic          start_spam;
    logic [SW-1:0] in_slice;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] out_prev;
    logic [SW-1:0] out_curr;
    logic [IW-1:0] out_idx;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;
    int ready_mode = 0;
    bit spam_en = 1'b0;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [SW-1:0] prev;
        logic [SW-1:0] curr;
    } pair_t;

    pair_t exp_q[$];

    assign start = start_main | start_spam;

    theta_slice_feeder #(.SLICE_W(SW), .NUM_SLICES(N), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_slice(in_slice), .in_valid(in_valid), .in_ready(in_ready),
        .out_prev(out_prev), .out_curr(out_curr), .out_idx(out_idx),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Downstream ready pattern: always, 1-0-0 repeating, or random.
    initial begin
        int rcnt;
        rcnt = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rcnt++;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (rcnt % 3 == 0);
                default: out_ready = 1'($urandom % 2);
            endcase
        end
    end

    // Spurious start pulses while the feeder is busy or finishing.
    initial begin
        start_spam = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            start_spam = spam_en && (done || (busy && ($urandom % 2 == 1)));
        end
    end

    // Monitor: pops the scoreboard on every output handshake, checks stall
    // stability and the done pulse timing.
    initial begin
        pair_t got;
        pair_t want;
        pair_t held;
        bit    stalled;
        bit    done_pend;
        stalled   = 1'b0;
        done_pend = 1'b0;
        held      = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled   = 1'b0;
                done_pend = 1'b0;
            end else begin
                got = '{idx: out_idx, prev: out_prev, curr: out_curr};
                if (stalled) begin
                    chk("stall_hold_valid", 64'(out_valid), 64'(1));
                    chk("stall_hold_pair", 64'(got), 64'(held));
                end
                if (done || done_pend) begin
                    chk("done_pulse", 64'(done), 64'(done_pend));
                end
                done_pend = 1'b0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pair", 64'(got), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        want = exp_q.pop_front();
                        chk("pair", 64'(got), 64'(want));
                    end
                    done_pend = (out_idx == IW'(N - 1));
                end
                stalled = out_valid && !out_ready;
                held    = got;
            end
        end
    end

    // Reference: pair k presents slice (k-1) mod N and slice k.
    function automatic void push_state(input logic [SW-1:0] d[N]);
        for (int k = 0; k < N; k++) begin
            exp_q.push_back('{idx: IW'(k), prev: d[(k + N - 1) % N], curr: d[k]});
        end
    endfunction

    task automatic run_state(input int kind, input int base, input bit gaps,
                             input bit check_busy, input int abort_idx);
        logic [SW-1:0] d[N];
        bit v;
        int z;
        int cyc;
        int bc;
        int to;
        bit got_done;
        for (int i = 0; i < N; i++) begin
            d[i] = (kind == 0) ? SW'(base + i) : SW'($urandom);
        end
        push_state(d);
        start_main = 1'b1;
        @(posedge clk);
        #1;
        start_main = 1'b0;
        z = 0; cyc = 0; bc = 0; to = 0;
        while (z < N && to < 1000) begin
            v = gaps ? (cyc % 3 != 2) : 1'b1;
            in_valid = v;
            in_slice = v ? d[z] : SW'($urandom);
            @(negedge clk);
            chk("load_in_ready", 64'(in_ready), 64'(1));
            if (busy) bc++;
            @(posedge clk);
            #1;
            if (v) z++;
            cyc++;
            to++;
        end
        in_valid = 1'b0;
        chk("load_complete", 64'(z), 64'(N));
        chk("first_valid", 64'(out_valid), 64'(1));
        chk("first_idx", 64'(out_idx), 64'(0));
        if (abort_idx >= 0) begin
            to = 0;
            while (!(out_valid && out_idx == IW'(abort_idx)) && to < 1000) begin
                @(posedge clk);
                #1;
                to++;
            end
            chk("abort_reached", 64'(out_idx), 64'(abort_idx));
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            exp_q.delete();
            chk("abort_valid", 64'(out_valid), 64'(0));
            chk("abort_busy", 64'(busy), 64'(0));
            chk("abort_done", 64'(done), 64'(0));
            chk("abort_idx", 64'(out_idx), 64'(0));
            return;
        end
        got_done = 1'b0;
        to = 0;
        while (!got_done && to < 3000) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) got_done = 1'b1;
            to++;
        end
        chk("done_seen", 64'(got_done), 64'(1));
        chk("done_busy_low", 64'(busy), 64'(0));
        chk("done_valid_low", 64'(out_valid), 64'(0));
        chk("done_queue_empty", 64'(exp_q.size()), 64'(0));
        if (check_busy) chk("busy_cycles", 64'(bc), 64'(2 * N));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        rst        = 1'b1;
        start_main = 1'b0;
        in_valid   = 1'b0;
        in_slice   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_outputs", 64'({out_prev, out_curr, out_idx}), 64'(0));
        chk("rst_busy_done", 64'({busy, done}), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back, then with a 1-0-0 ready pattern.
        ready_mode = 0;
        run_state(0, 1, 1'b0, 1'b1, -1);
        ready_mode = 1;
        run_state(0, 1, 1'b0, 1'b0, -1);

        // Load gaps every third cycle.
        ready_mode = 0;
        run_state(1, 0, 1'b1, 1'b0, -1);

        // Spurious start pulses in LOAD, STREAM and DONE.
        spam_en = 1'b1;
        run_state(0, 1, 1'b0, 1'b1, -1);
        spam_en = 1'b0;
        @(posedge clk);
        #1;

        // Reset after ten slices, then a fresh state.
        start_main = 1'b1;
        @(posedge clk);
        #1;
        start_main = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_slice = SW'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midload_rst_ready", 64'(in_ready), 64'(0));
        chk("midload_rst_busy", 64'({busy, done, out_valid}), 64'(0));
        @(posedge clk);
        #1;
        run_state(0, 'h100, 1'b0, 1'b0, -1);

        // Reset during streaming at pair 20, then recover.
        run_state(1, 0, 1'b0, 1'b0, 20);
        @(posedge clk);
        #1;

        // Random data, random gaps and random backpressure.
        ready_mode = 2;
        run_state(1, 0, 1'b1, 1'b0, -1);
        run_state(1, 0, 1'b0, 1'b0, -1);

        chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
